// File: rtl/reg_file_mp.sv
// Multi-port register file with two writeback ports and a per-register busy scoreboard.
// Define REG_FILE_BYPASS_EN to forward same-cycle writes to the read ports.
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     WE_A,
    input  logic [ADDR_W-1:0]        WADDR_A,
    input  logic [DATA_W-1:0]        WDATA_A,
    input  logic                     WE_B,
    input  logic [ADDR_W-1:0]        WADDR_B,
    input  logic [DATA_W-1:0]        WDATA_B,
    input  logic                     RSV_EN,
    input  logic [ADDR_W-1:0]        RSV_ADDR,
    input  logic                     FLUSH,
    input  logic [NUM_RD*ADDR_W-1:0] RADDR,
    output logic [NUM_RD*DATA_W-1:0] RDATA,
    output logic [NUM_RD-1:0]        RBUSY,
    output logic                     ANY_BUSY
);

    localparam int NUM_REGS = 2**ADDR_W;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic                wr_a_ok;
    logic                wr_b_ok;
    logic                rsv_ok;

    // Register 0 is hard-wired when ZERO_REG is set: writes and reserves to it are dropped.
    assign wr_a_ok = WE_A   && !((ZERO_REG != 0) && (WADDR_A  == '0));
    assign wr_b_ok = WE_B   && !((ZERO_REG != 0) && (WADDR_B  == '0));
    assign rsv_ok  = RSV_EN && !((ZERO_REG != 0) && (RSV_ADDR == '0));

    // Flush clears first, writes clear next, reserve sets last so a new producer wins.
    always_comb begin
        busy_nxt = FLUSH ? '0 : busy;
        if (wr_a_ok) busy_nxt[WADDR_A] = 1'b0;
        if (wr_b_ok) busy_nxt[WADDR_B] = 1'b0;
        if (rsv_ok)  busy_nxt[RSV_ADDR] = 1'b1;
    end

    always_ff @(negedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (wr_a_ok) regs[WADDR_A] <= WDATA_A;
            // Port B is assigned last so it owns a same-address collision.
            if (wr_b_ok) regs[WADDR_B] <= WDATA_B;
            busy <= busy_nxt;
        end
    end

    assign ANY_BUSY = |busy;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] arr_data;

        assign ra       = RADDR[k*ADDR_W +: ADDR_W];
        assign arr_data = ((ZERO_REG != 0) && (ra == '0)) ? '0 : regs[ra];

`ifdef REG_FILE_BYPASS_EN
        logic hit_a;
        logic hit_b;
        logic rsv_hit;

        // Forwarding is suppressed while in reset so the outputs read as cleared.
        assign hit_a   = RESET && wr_a_ok && (WADDR_A == ra);
        assign hit_b   = RESET && wr_b_ok && (WADDR_B == ra);
        assign rsv_hit = rsv_ok && (RSV_ADDR == ra);

        assign RDATA[k*DATA_W +: DATA_W] = hit_b ? WDATA_B :
                                           hit_a ? WDATA_A : arr_data;
        assign RBUSY[k] = (hit_a || hit_b) ? rsv_hit : busy[ra];
`else
        assign RDATA[k*DATA_W +: DATA_W] = arr_data;
        assign RBUSY[k]                  = busy[ra];
`endif
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: vector table, corner sequences, randomized model compare.
module tb_reg_file_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 4;
    localparam int NREGS = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             we_a, we_b, rsv_en, flush;
    logic [AW-1:0]    waddr_a, waddr_b, rsv_addr;
    logic [DW-1:0]    wdata_a, wdata_b;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0]    rbusy;
    logic             any_busy;

    int n_vec  = 0;
    int n_miss = 0;

    logic [DW-1:0] mreg  [NREGS];
    bit            mbusy [NREGS];

    typedef struct {
        logic          we_a;
        logic [AW-1:0] wa;
        logic [DW-1:0] wda;
        logic          we_b;
        logic [AW-1:0] wb;
        logic [DW-1:0] wdb;
        logic          rsv;
        logic [AW-1:0] ra;
        logic          flush;
        logic [AW-1:0] rd;
        logic [DW-1:0] exp_data;
        logic          exp_busy;
        logic          exp_any;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) u_dut (
        .CLK(clk), .RESET(reset),
        .WE_A(we_a), .WADDR_A(waddr_a), .WDATA_A(wdata_a),
        .WE_B(we_b), .WADDR_B(waddr_b), .WDATA_B(wdata_b),
        .RSV_EN(rsv_en), .RSV_ADDR(rsv_addr), .FLUSH(flush),
        .RADDR(raddr), .RDATA(rdata), .RBUSY(rbusy), .ANY_BUSY(any_busy)
    );

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        we_a = 0; waddr_a = '0; wdata_a = '0;
        we_b = 0; waddr_b = '0; wdata_b = '0;
        rsv_en = 0; rsv_addr = '0; flush = 0;
    endtask

    task automatic set_rd(input int k, input logic [AW-1:0] a);
        raddr[k*AW +: AW] = a;
    endtask

    function automatic logic [DW-1:0] rd_data(input int k);
        return rdata[k*DW +: DW];
    endfunction

    task automatic add_vec(input logic wea, input logic [AW-1:0] wa, input logic [DW-1:0] wda,
                           input logic web, input logic [AW-1:0] wb, input logic [DW-1:0] wdb,
                           input logic rsv, input logic [AW-1:0] ra, input logic fl,
                           input logic [AW-1:0] rd, input logic [DW-1:0] ed,
                           input logic eb, input logic ea);
        vec_t v;
        v.we_a = wea; v.wa = wa; v.wda = wda;
        v.we_b = web; v.wb = wb; v.wdb = wdb;
        v.rsv = rsv; v.ra = ra; v.flush = fl; v.rd = rd;
        v.exp_data = ed; v.exp_busy = eb; v.exp_any = ea;
        tbl.push_back(v);
    endtask

    // Reference model: the architectural effect of one falling edge.
    task automatic model_edge();
        if (flush) for (int i = 0; i < NREGS; i++) mbusy[i] = 0;
        if (we_a && waddr_a != 0) begin mreg[waddr_a] = wdata_a; mbusy[waddr_a] = 0; end
        if (we_b && waddr_b != 0) begin mreg[waddr_b] = wdata_b; mbusy[waddr_b] = 0; end
        if (rsv_en && rsv_addr != 0) mbusy[rsv_addr] = 1;
    endtask

    function automatic logic model_any();
        logic r = 0;
        for (int i = 0; i < NREGS; i++) r = r | mbusy[i];
        return r;
    endfunction

    function automatic logic [DW-1:0] exp_pre_data(input logic [AW-1:0] a);
`ifdef REG_FILE_BYPASS_EN
        if (we_b && waddr_b != 0 && waddr_b == a) return wdata_b;
        if (we_a && waddr_a != 0 && waddr_a == a) return wdata_a;
`endif
        return (a == 0) ? '0 : mreg[a];
    endfunction

    function automatic logic exp_pre_busy(input logic [AW-1:0] a);
`ifdef REG_FILE_BYPASS_EN
        if ((we_b && waddr_b != 0 && waddr_b == a) || (we_a && waddr_a != 0 && waddr_a == a))
            return rsv_en && rsv_addr != 0 && rsv_addr == a;
`endif
        return mbusy[a];
    endfunction

    function automatic logic [AW-1:0] rnd_addr();
        logic [AW-1:0] a;
        if ($urandom_range(0, 1) == 0) a = AW'($urandom_range(0, 7));
        else                           a = AW'($urandom_range(0, NREGS-1));
        return a;
    endfunction

    initial begin
        idle_inputs();
        raddr = '0;
        reset = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NR; k++) begin
            chk("reset_rdata", rd_data(k), '0);
            chk("reset_rbusy", rbusy[k], 0);
        end
        chk("reset_any", any_busy, 0);
        reset = 1;

        // Write x5 and observe before and after the falling edge.
        @(posedge clk); #1;
        we_a = 1; waddr_a = 5; wdata_a = 32'hDEAD_BEEF;
        for (int k = 0; k < NR; k++) set_rd(k, 5);
        #2;
`ifdef REG_FILE_BYPASS_EN
        chk("x5_pre_negedge", rd_data(0), 32'hDEAD_BEEF);
`else
        chk("x5_pre_negedge", rd_data(0), 32'h0);
`endif
        @(negedge clk); #1;
        chk("x5_post_negedge", rd_data(0), 32'hDEAD_BEEF);
        @(posedge clk); #1;
        idle_inputs();

        add_vec(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 5, 32'hDEAD_BEEF, 0, 0);
        add_vec(1, 7, 32'h1, 1, 7, 32'h2, 0, 0, 0, 7, 32'h2, 0, 0);
        add_vec(0, 0, 0, 0, 0, 0, 1, 9, 0, 9, 32'h0, 1, 1);
        add_vec(0, 0, 0, 1, 9, 32'h55, 0, 0, 0, 9, 32'h55, 0, 0);
        add_vec(1, 9, 32'h66, 0, 0, 0, 1, 9, 0, 9, 32'h66, 1, 1);
        add_vec(1, 3, 32'h33, 0, 0, 0, 1, 3, 0, 3, 32'h33, 1, 1);
        add_vec(0, 0, 0, 0, 0, 0, 1, 4, 0, 5, 32'hDEAD_BEEF, 0, 1);
        add_vec(0, 0, 0, 0, 0, 0, 1, 10, 0, 10, 32'h0, 1, 1);
        add_vec(0, 0, 0, 0, 0, 0, 1, 12, 1, 12, 32'h0, 1, 1);
        add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 32'h33, 0, 1);
        add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 32'h66, 0, 1);
        add_vec(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 1, 0, 0, 0, 32'h0, 0, 1);
        add_vec(0, 0, 0, 1, 12, 32'hC, 0, 0, 0, 12, 32'hC, 0, 0);

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            we_a = tbl[i].we_a; waddr_a = tbl[i].wa; wdata_a = tbl[i].wda;
            we_b = tbl[i].we_b; waddr_b = tbl[i].wb; wdata_b = tbl[i].wdb;
            rsv_en = tbl[i].rsv; rsv_addr = tbl[i].ra; flush = tbl[i].flush;
            for (int k = 0; k < NR; k++) set_rd(k, tbl[i].rd);
            @(negedge clk); #1;
            for (int k = 0; k < NR; k++) begin
                chk($sformatf("tbl%0d_rdata%0d", i, k), rd_data(k), tbl[i].exp_data);
                chk($sformatf("tbl%0d_rbusy%0d", i, k), rbusy[k], tbl[i].exp_busy);
            end
            chk($sformatf("tbl%0d_any", i), any_busy, tbl[i].exp_any);
        end
        @(posedge clk); #1;
        idle_inputs();

        // Fill x1..x31, reserve one, then pull reset mid-cycle.
        for (int r = 1; r < NREGS; r++) begin
            we_a = 1; waddr_a = AW'(r); wdata_a = 32'h1000_0000 + DW'(r);
            rsv_en = (r == 31); rsv_addr = 20;
            @(posedge clk); #1;
        end
        idle_inputs();
        set_rd(0, 1); set_rd(1, 17); set_rd(2, 31); set_rd(3, 20);
        #1;
        chk("fill_x17", rd_data(1), 32'h1000_0011);
        chk("fill_x20_busy", rbusy[3], 1);
        reset = 0;
        we_a = 1; waddr_a = 8; wdata_a = 32'hAAAA_AAAA;
        rsv_en = 1; rsv_addr = 8;
        #1;
        for (int k = 0; k < NR; k++) begin
            chk("async_rst_rdata", rd_data(k), '0);
            chk("async_rst_rbusy", rbusy[k], 0);
        end
        chk("async_rst_any", any_busy, 0);
        set_rd(0, 8);
        @(negedge clk); #1;
        chk("rst_write_dropped", rd_data(0), '0);
        chk("rst_rsv_dropped", any_busy, 0);
        @(posedge clk); #1;
        idle_inputs();
        reset = 1;
        @(negedge clk); #1;
        chk("post_rst_x8", rd_data(0), '0);
        chk("post_rst_x8_busy", rbusy[0], 0);

        // Randomized phase against the model, starting from the reset state.
        for (int i = 0; i < NREGS; i++) begin mreg[i] = '0; mbusy[i] = 0; end
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            we_a = ($urandom_range(0, 2) == 0); waddr_a = rnd_addr(); wdata_a = $urandom;
            we_b = ($urandom_range(0, 2) == 0); waddr_b = rnd_addr(); wdata_b = $urandom;
            rsv_en = ($urandom_range(0, 2) == 0); rsv_addr = rnd_addr();
            flush = ($urandom_range(0, 15) == 0);
            for (int k = 0; k < NR; k++) set_rd(k, rnd_addr());
            #2;
            for (int k = 0; k < NR; k++) begin
                chk($sformatf("rnd%0d_pre_rdata%0d", c, k), rd_data(k),
                    exp_pre_data(raddr[k*AW +: AW]));
                chk($sformatf("rnd%0d_pre_rbusy%0d", c, k), rbusy[k],
                    exp_pre_busy(raddr[k*AW +: AW]));
            end
            chk($sformatf("rnd%0d_pre_any", c), any_busy, model_any());
            @(negedge clk);
            model_edge();
            #1;
            for (int k = 0; k < NR; k++) begin
                chk($sformatf("rnd%0d_rdata%0d", c, k), rd_data(k),
                    (raddr[k*AW +: AW] == 0) ? '0 : mreg[raddr[k*AW +: AW]]);
                chk($sformatf("rnd%0d_rbusy%0d", c, k), rbusy[k], mbusy[raddr[k*AW +: AW]]);
            end
            chk($sformatf("rnd%0d_any", c), any_busy, model_any());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
